// File: rtl/conv_layer_scheduler.sv
// Layer sequencer for the 5x5 convolution engine. It walks the (output, input) channel pairs,
// offsets the engine addresses into planar memories, and read-modify-writes results into the accumulator.
module conv_layer_scheduler #(
  parameter int data_size               = 8,
  parameter int out_data_size           = 24,
  parameter int acc_size                = 32,
  parameter int img_size                = 128,
  parameter int img_address_size        = 14,
  parameter int weight_address_size     = 8,
  parameter int out_address_size        = 17,
  parameter int img_mem_address_size    = 18,
  parameter int weight_mem_address_size = 12,
  parameter int acc_address_size        = 20,
  parameter int ch_size                 = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [ch_size-1:0]                 num_in_ch,
  input  logic [ch_size-1:0]                 num_out_ch,
  output logic                               busy,
  output logic                               done,
  output logic                               eng_start,
  input  logic                               eng_done,
  input  logic [img_address_size-1:0]        eng_img_address,
  input  logic [weight_address_size-1:0]     eng_weight_address,
  input  logic                               eng_out_valid,
  input  logic [out_address_size-1:0]        eng_out_address,
  input  logic [out_data_size-1:0]           eng_out_data,
  output logic [img_mem_address_size-1:0]    img_address,
  output logic [weight_mem_address_size-1:0] weight_address,
  output logic                               acc_rd_en,
  output logic [acc_address_size-1:0]        acc_rd_address,
  input  logic [acc_size-1:0]                acc_rd_data,
  output logic                               acc_wr_en,
  output logic [acc_address_size-1:0]        acc_wr_address,
  output logic [acc_size-1:0]                acc_wr_data
);

  if (data_size < 1 || acc_size < out_data_size) begin : g_bad_param
    $error("conv_layer_scheduler: accumulator narrower than engine result");
  end

  typedef enum logic [2:0] {IDLE, ENG_START, ENG_WAIT, DRAIN, NEXT, FINISH} state_t;

  // Per-step base increments are elaboration constants, so the datapath needs adders only.
  localparam logic [img_mem_address_size-1:0]    PLANE     = img_mem_address_size'(img_size * img_size);
  localparam logic [acc_address_size-1:0]        OUT_PLANE = acc_address_size'((img_size - 4) * (img_size - 4));
  localparam logic [weight_mem_address_size-1:0] KERNEL    = weight_mem_address_size'(25);

  state_t                               state, state_nxt;
  logic [ch_size-1:0]                   nin, nout, ic, oc;
  logic [img_mem_address_size-1:0]      img_base;
  logic [weight_mem_address_size-1:0]   w_base;
  logic [acc_address_size-1:0]          out_base;
  logic                                 last_ic, last_oc, zero_cnt;

  assign last_ic  = (ic == nin - ch_size'(1));
  assign last_oc  = (oc == nout - ch_size'(1));
  assign zero_cnt = (num_in_ch == '0) || (num_out_ch == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    eng_start = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = zero_cnt ? FINISH : ENG_START;
      end
      ENG_START: begin
        eng_start = 1'b1;
        state_nxt = ENG_WAIT;
      end
      ENG_WAIT:  if (eng_done) state_nxt = DRAIN;
      DRAIN:     state_nxt = NEXT;
      NEXT:      state_nxt = (last_ic && last_oc) ? FINISH : ENG_START;
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nin      <= '0;
      nout     <= '0;
      ic       <= '0;
      oc       <= '0;
      img_base <= '0;
      w_base   <= '0;
      out_base <= '0;
    end else if (state == IDLE && start) begin
      nin      <= num_in_ch;
      nout     <= num_out_ch;
      ic       <= '0;
      oc       <= '0;
      img_base <= '0;
      w_base   <= '0;
      out_base <= '0;
    end else if (state == NEXT) begin
      w_base <= w_base + KERNEL;
      if (!last_ic) begin
        ic       <= ic + ch_size'(1);
        img_base <= img_base + PLANE;
      end else if (!last_oc) begin
        ic       <= '0;
        img_base <= '0;
        oc       <= oc + ch_size'(1);
        out_base <= out_base + OUT_PLANE;
      end
    end
  end

  assign img_address    = img_base + img_mem_address_size'(eng_img_address);
  assign weight_address = w_base + weight_mem_address_size'(eng_weight_address);

  // Stage 0: a beat issues its accumulator read in the same cycle it arrives.
  logic                        beat;
  logic [acc_address_size-1:0] beat_addr;

  assign beat           = eng_out_valid &&
                          (state == ENG_START || state == ENG_WAIT || state == DRAIN);
  assign beat_addr      = out_base + acc_address_size'(eng_out_address);
  assign acc_rd_en      = beat;
  assign acc_rd_address = beat ? beat_addr : '0;

  // Stage 1: read data returns, the sum is written back to the same word.
  logic                        s1_vld, s1_first;
  logic [acc_address_size-1:0] s1_addr;
  logic [out_data_size-1:0]    s1_data;
  logic [acc_size-1:0]         s1_sext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_vld <= beat;
      if (beat) begin
        s1_first <= (ic == '0);
        s1_addr  <= beat_addr;
        s1_data  <= eng_out_data;
      end
    end
  end

  assign s1_sext        = {{(acc_size - out_data_size){s1_data[out_data_size-1]}}, s1_data};
  assign acc_wr_en      = s1_vld;
  assign acc_wr_address = s1_vld ? s1_addr : '0;
  assign acc_wr_data    = !s1_vld  ? '0 :
                          s1_first ? s1_sext : acc_rd_data + s1_sext;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler: a scripted engine model plus a 1-cycle-latency
// accumulator memory, with hand-computed expected words and handshake timing.
module tb_conv_layer_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num_in_ch = '0, num_out_ch = '0;
  logic        busy, done, eng_start;
  logic        eng_done = 1'b0;
  logic [13:0] eng_img_address = '0;
  logic [7:0]  eng_weight_address = '0;
  logic        eng_out_valid = 1'b0;
  logic [16:0] eng_out_address = '0;
  logic [23:0] eng_out_data = '0;
  logic [17:0] img_address;
  logic [11:0] weight_address;
  logic        acc_rd_en;
  logic [19:0] acc_rd_address;
  logic [31:0] acc_rd_data = '0;
  logic        acc_wr_en;
  logic [19:0] acc_wr_address;
  logic [31:0] acc_wr_data;

  conv_layer_scheduler #(.img_size(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_in_ch(num_in_ch), .num_out_ch(num_out_ch),
    .busy(busy), .done(done), .eng_start(eng_start), .eng_done(eng_done),
    .eng_img_address(eng_img_address), .eng_weight_address(eng_weight_address),
    .eng_out_valid(eng_out_valid), .eng_out_address(eng_out_address), .eng_out_data(eng_out_data),
    .img_address(img_address), .weight_address(weight_address),
    .acc_rd_en(acc_rd_en), .acc_rd_address(acc_rd_address), .acc_rd_data(acc_rd_data),
    .acc_wr_en(acc_wr_en), .acc_wr_address(acc_wr_address), .acc_wr_data(acc_wr_data));

  always #5 clk = ~clk;

  // Accumulator memory and activity counters.
  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  int n_start = 0, n_done = 0, n_wr = 0;

  always @(posedge clk) begin
    if (acc_rd_en) acc_rd_data <= mem[acc_rd_address[9:0]];
    if (acc_wr_en) mem[acc_wr_address[9:0]] <= acc_wr_data;
    if (pl_en)     mem[pl_addr] <= pl_data;
    if (eng_start) n_start <= n_start + 1;
    if (done)      n_done  <= n_done + 1;
    if (acc_wr_en) n_wr    <= n_wr + 1;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_layer(input logic [3:0] nin, input logic [3:0] nout);
    @(posedge clk); #1;
    num_in_ch = nin; num_out_ch = nout; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One kernel: wait for eng_start, emit n beats of val at a0.., then pulse eng_done.
  task automatic kernel(input int n, input int a0, input logic [23:0] val,
                        input int img_off, input int w_off, input int obase);
    bit seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (eng_start) seen = 1;
    end
    chk("eng_start_seen", 32'(seen), 32'd1);
    chk("busy_in_kernel", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      eng_img_address = 14'd5; eng_weight_address = 8'd3;
      eng_out_valid = 1'b1; eng_out_address = 17'(a0 + i); eng_out_data = val;
      @(negedge clk);
      if (i == 0) begin
        chk("img_address", 32'(img_address), 32'(img_off + 5));
        chk("weight_address", 32'(weight_address), 32'(w_off + 3));
        chk("rd_en_beat0", 32'(acc_rd_en), 32'd1);
        chk("rd_addr_beat0", 32'(acc_rd_address), 32'(obase + a0));
      end
      if (i == 1) begin
        chk("wr_en_beat0", 32'(acc_wr_en), 32'd1);
        chk("wr_addr_beat0", 32'(acc_wr_address), 32'(obase + a0));
      end
    end
    @(posedge clk); #1;
    eng_out_valid = 1'b0; eng_done = 1'b1;
    @(negedge clk);
    if (n == 1) begin
      chk("wr_en_beat0", 32'(acc_wr_en), 32'd1);
      chk("wr_addr_beat0", 32'(acc_wr_address), 32'(obase + a0));
    end
    @(posedge clk); #1;
    eng_done = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  int s0, d0, w0;

  initial begin
    // Reset values
    eng_img_address = 14'd7; eng_weight_address = 8'd9;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_rd_en", 32'(acc_rd_en), 32'd0);
    chk("rst_wr_en", 32'(acc_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(acc_wr_address), 32'd0);
    chk("rst_wr_data", acc_wr_data, 32'd0);
    chk("rst_img_addr", 32'(img_address), 32'd7);
    chk("rst_w_addr", 32'(weight_address), 32'd9);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1x1 layer, 16 beats of 3; a start pulse mid-layer must be ignored
    s0 = n_start; d0 = n_done; w0 = n_wr;
    start_layer(4'd1, 4'd1);
    kernel(16, 0, 24'd3, 0, 0, 0);
    num_in_ch = 4'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    chk("t1_starts", 32'(n_start - s0), 32'd1);
    chk("t1_dones", 32'(n_done - d0), 32'd1);
    chk("t1_writes", 32'(n_wr - w0), 32'd16);
    chk("t1_mem0", mem[0], 32'd3);
    chk("t1_mem15", mem[15], 32'd3);

    // 3 input channels: -2 + 5 + 5 = 8
    w0 = n_wr;
    start_layer(4'd3, 4'd1);
    kernel(16, 0, 24'hFFFFFE, 0, 0, 0);
    kernel(16, 0, 24'd5, 64, 25, 0);
    kernel(16, 0, 24'd5, 128, 50, 0);
    wait_done();
    chk("t2_writes", 32'(n_wr - w0), 32'd48);
    chk("t2_mem0", mem[0], 32'd8);
    chk("t2_mem15", mem[15], 32'd8);

    // 2x2 channels: out plane 1 lands at 16..31
    s0 = n_start; w0 = n_wr;
    start_layer(4'd2, 4'd2);
    kernel(16, 0, 24'd1, 0, 0, 0);
    kernel(16, 0, 24'd2, 64, 25, 0);
    kernel(16, 0, 24'd4, 0, 50, 16);
    kernel(16, 0, 24'd1, 64, 75, 16);
    wait_done();
    chk("t3_starts", 32'(n_start - s0), 32'd4);
    chk("t3_writes", 32'(n_wr - w0), 32'd64);
    chk("t3_mem0", mem[0], 32'd3);
    chk("t3_mem16", mem[16], 32'd5);
    chk("t3_mem31", mem[31], 32'd5);

    // Zero output channels: done one cycle after start, nothing else
    s0 = n_start; w0 = n_wr;
    start_layer(4'd2, 4'd0);
    @(negedge clk);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t4_done_clr", 32'(done), 32'd0);
    chk("t4_busy_clr", 32'(busy), 32'd0);
    @(posedge clk); #1 eng_out_valid = 1'b1; eng_out_address = 17'd3;
    @(negedge clk);
    chk("t4_idle_rd_en", 32'(acc_rd_en), 32'd0);
    @(posedge clk); #1 eng_out_valid = 1'b0;
    @(negedge clk);
    chk("t4_idle_wr_en", 32'(acc_wr_en), 32'd0);
    chk("t4_starts", 32'(n_start - s0), 32'd0);
    chk("t4_writes", 32'(n_wr - w0), 32'd0);

    // Wrap and sign extension
    @(posedge clk); #1 pl_en = 1'b1; pl_addr = 10'd0; pl_data = 32'h7FFFFFFF;
    @(posedge clk); #1 pl_en = 1'b0;
    start_layer(4'd2, 4'd1);
    kernel(1, 1, 24'hFFFFFF, 0, 0, 0);
    kernel(1, 0, 24'd1, 64, 25, 0);
    wait_done();
    chk("t5_neg_first", mem[1], 32'hFFFFFFFF);
    chk("t5_wrap", mem[0], 32'h80000000);

    // Reset in ENG_WAIT, then late engine activity is ignored
    w0 = n_wr;
    start_layer(4'd1, 4'd1);
    @(negedge clk);
    chk("t6_eng_start", 32'(eng_start), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    eng_done = 1'b1; eng_out_valid = 1'b1; eng_out_address = 17'd2; eng_out_data = 24'd9;
    @(negedge clk);
    chk("t6_late_rd_en", 32'(acc_rd_en), 32'd0);
    @(posedge clk); #1 eng_done = 1'b0; eng_out_valid = 1'b0;
    @(negedge clk);
    chk("t6_late_wr_en", 32'(acc_wr_en), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_writes", 32'(n_wr - w0), 32'd0);
    start_layer(4'd1, 4'd1);
    kernel(2, 0, 24'd7, 0, 0, 0);
    wait_done();
    chk("t6_mem0", mem[0], 32'd7);
    chk("t6_mem1", mem[1], 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
